sink_stats_scheduler: RTL
=========================

# sink_stats_scheduler

Measurement-window controller and statistics readout scheduler for the emulator's packet sinks. It generates the shared 16-bit timestamp, sequences a run through warm-up, measurement and drain phases (gating traffic sources and clearing sinks), then serialises every port's sink counters over one valid/ready record channel to the host-side collector. It sits between the N `packet_sink` instances and the statistics/host interface.

## Interface
- `NUM_PORTS`, default 8: number of sink ports; range 1..64.
- `PORT_W`, default `$clog2(NUM_PORTS)` (minimum 1): width of `rec_port`.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE and DONE.
- `abort` input 1: terminate the run; return to IDLE.
- `warmup_cycles`, `measure_cycles`, `drain_cycles` input 16 each: phase lengths, captured on `start`.
- `sink_latency` input `[NUM_PORTS][24]`: per-port accumulated latency.
- `sink_count` input `[NUM_PORTS][16]`: per-port packet count.
- `sink_error` input `[NUM_PORTS]`: per-port misroute flag.
- `timestamp` output 16: free-running cycle counter driven to sources and sinks.
- `src_en` output 1: traffic sources may inject.
- `sink_clr` output 1: drives the sinks' reset input; OR-ed externally with `rst`.
- `busy` output 1: high in WARMUP, MEASURE, DRAIN and READOUT.
- `done` output 1: high in DONE.
- `rec_valid` output 1; `rec_ready` input 1: record handshake.
- `rec_port` output `PORT_W`; `rec_latency` output 24; `rec_count` output 16; `rec_error` output 1: record payload.

## Operation
- States: IDLE, WARMUP, MEASURE, DRAIN, READOUT, DONE.
- Outputs by state:
  - IDLE: `sink_clr`=1, `src_en`=0.
  - WARMUP: `sink_clr`=1, `src_en`=1.
  - MEASURE: `sink_clr`=0, `src_en`=1.
  - DRAIN: `sink_clr`=0, `src_en`=0.
  - READOUT and DONE: `sink_clr`=0, `src_en`=0.
- Phase timer: loads the phase length on entry. A phase lasts max(N,1) cycles, so a length of 0 behaves as 1. On expiry the block moves to the next phase.
- IDLE or DONE with `start`=1: go to WARMUP and capture the three lengths. A later `start` is ignored until DONE.
- READOUT: port index p runs 0..NUM_PORTS-1. The record for port p is captured into output registers from the sink inputs. Payload is stable while `rec_valid && !rec_ready`.
- On handshake at port p < NUM_PORTS-1: the port p+1 record is captured on the same edge. With `rec_ready` held high, throughput is one record per cycle.
- On the last handshake: go to DONE and drop `rec_valid`.
- `abort` in any state: go to IDLE next cycle, `rec_valid` to 0, port index cleared, `src_en` low. `abort` has priority over `start` and over a simultaneous handshake; that handshake does not count.
- `timestamp`: increments every cycle from reset, wraps 0xFFFF to 0x0000, and is never cleared by `start` or `abort`. Latency arithmetic in the sinks is modulo 2^16.

## Timing
- Reset values:
  - State IDLE.
  - `timestamp`=0.
  - `src_en`=0, `sink_clr`=1, `busy`=0, `done`=0.
  - `rec_valid`=0; all record fields 0.
  - Totals 0.
- All outputs are registered.
- `start` at edge k: WARMUP from cycle k+1, with `src_en`=1 and `sink_clr`=1.
- Entry to READOUT at cycle j: `rec_valid`=1 with port 0 data at cycle j+1. The cycle-j capture sees counts frozen after DRAIN.
- `rst` mid-run: identical to `abort`, and also zeroes `timestamp`.

## Configuration
- `SINK_SCHED_TOTALS_EN` defined:
  - Adds outputs `total_latency` (32) and `total_count` (24) and `any_error` (1).
  - These accumulate the zero-extended record fields on each accepted handshake.
  - They are cleared on `start`, `abort` and `rst`, and hold their values in DONE.
- `SINK_SCHED_TOTALS_EN` undefined: these ports and their logic do not exist.

## Structure
- Shared package (`config.sv` scope): `sched_state_t` enum, `stat_rec_t` struct (port, latency, count, error), and `NUM_PORTS` default.
- One sub-module, `phase_timer`: a 16-bit loadable down-counter with load, length and expired signals.

## Test plan
- Reset, then 3 idle cycles: `timestamp`=3, `sink_clr`=1, `src_en`=0, `rec_valid`=0.
- `start` with lengths 4/10/2 and `rec_ready`=1:
  - WARMUP 4 cycles, MEASURE 10, DRAIN 2.
  - 8 records then follow on consecutive cycles with `rec_port` 0..7.
  - `done`=1 after the last record.
- Sinks driven with count=5·p and latency=100·p, and `rec_ready` toggled 1-0-1:
  - Payloads match per port and stay stable during stalls.
  - With the macro defined: `total_count`=140 and `total_latency`=2800.
- Lengths 0/0/0: each phase lasts exactly 1 cycle; READOUT begins at cycle k+4.
- `abort` during MEASURE, and separately on the handshake of port 3:
  - IDLE next cycle, `rec_valid`=0.
  - A new `start` restarts from port 0.
- Long run: `timestamp` wraps 0xFFFF→0x0000 with no glitch on `src_en`.

Source files
------------

// File: rtl/sink_stats_scheduler_pkg.sv
// Shared types for the sink statistics scheduler: FSM state encoding,
// the per-port statistics record layout and the default port count.
package sink_stats_scheduler_pkg;

    localparam int NUM_PORTS_DEF = 8;
    localparam int MAX_PORT_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_READOUT = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [MAX_PORT_W-1:0] port;
        logic [23:0]           latency;
        logic [15:0]           count;
        logic                  error;
    } stat_rec_t;

endpackage

// File: rtl/sink_stats_scheduler_phase_timer.sv
// Loadable 16-bit down-counter timing one run phase; a loaded length of N
// keeps expired_o low for max(N,1)-1 cycles, so the phase lasts max(N,1).
module phase_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] len_i,
    output logic        expired_o
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (len_i == 16'd0) ? 16'd0 : len_i - 16'd1;
        end else if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 16'd0);

endmodule

// File: rtl/sink_stats_scheduler.sv
// Measurement-window controller and per-port statistics readout scheduler.
// Optional running totals are built when SINK_SCHED_TOTALS_EN is defined.
module sink_stats_scheduler
    import sink_stats_scheduler_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [15:0]                 warmup_cycles_i,
    input  logic [15:0]                 measure_cycles_i,
    input  logic [15:0]                 drain_cycles_i,
    input  logic [NUM_PORTS-1:0][23:0]  sink_latency_i,
    input  logic [NUM_PORTS-1:0][15:0]  sink_count_i,
    input  logic [NUM_PORTS-1:0]        sink_error_i,
    output logic [15:0]                 timestamp_o,
    output logic                        src_en_o,
    output logic                        sink_clr_o,
    output logic                        busy_o,
    output logic                        done_o,
    output sched_state_t                state_o,
    input  logic                        rec_ready_i,
    output logic                        rec_valid_o,
    output logic [PORT_W-1:0]           rec_port_o,
    output logic [23:0]                 rec_latency_o,
    output logic [15:0]                 rec_count_o,
    output logic                        rec_error_o
`ifdef SINK_SCHED_TOTALS_EN
    ,
    output logic [31:0]                 total_latency_o,
    output logic [23:0]                 total_count_o,
    output logic                        any_error_o
`endif
);

    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    sched_state_t      state_q, state_d;
    logic [15:0]       meas_len_q, meas_len_d, drain_len_q, drain_len_d;
    logic [15:0]       ts_q;
    logic [PORT_W-1:0] port_q, port_d, cap_idx;
    stat_rec_t         rec_q, rec_d;
    logic              rec_valid_q, rec_valid_d;
    logic              src_en_q, sink_clr_q, busy_q, done_q;
    logic              timer_load, timer_expired;
    logic [15:0]       timer_len;
    logic              clr_totals, accept;

    phase_timer u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (timer_load),
        .len_i     (timer_len),
        .expired_o (timer_expired)
    );

    // Record channel: a record transfers on a cycle where rec_valid_o and
    // rec_ready_i are both high; while valid and not ready the payload holds.
    always_comb begin
        state_d     = state_q;
        meas_len_d  = meas_len_q;
        drain_len_d = drain_len_q;
        port_d      = port_q;
        rec_d       = rec_q;
        rec_valid_d = rec_valid_q;
        timer_load  = 1'b0;
        timer_len   = warmup_cycles_i;
        clr_totals  = 1'b0;
        accept      = 1'b0;
        cap_idx     = port_q;
        if (abort_i) begin
            state_d     = ST_IDLE;
            rec_valid_d = 1'b0;
            port_d      = '0;
            clr_totals  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d     = ST_WARMUP;
                        timer_load  = 1'b1;
                        timer_len   = warmup_cycles_i;
                        meas_len_d  = measure_cycles_i;
                        drain_len_d = drain_cycles_i;
                        clr_totals  = 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (timer_expired) begin
                        state_d    = ST_MEASURE;
                        timer_load = 1'b1;
                        timer_len  = meas_len_q;
                    end
                end
                ST_MEASURE: begin
                    if (timer_expired) begin
                        state_d    = ST_DRAIN;
                        timer_load = 1'b1;
                        timer_len  = drain_len_q;
                    end
                end
                ST_DRAIN: begin
                    if (timer_expired) begin
                        state_d = ST_READOUT;
                        port_d  = '0;
                    end
                end
                ST_READOUT: begin
                    // First READOUT cycle captures port 0 from the now-frozen sinks.
                    if (!rec_valid_q) begin
                        rec_valid_d = 1'b1;
                    end else if (rec_ready_i) begin
                        accept = 1'b1;
                        if (port_q == LAST_PORT) begin
                            state_d     = ST_DONE;
                            rec_valid_d = 1'b0;
                        end else begin
                            port_d  = port_q + 1'b1;
                            cap_idx = port_q + 1'b1;
                        end
                    end
                    if (!rec_valid_q || (rec_ready_i && port_q != LAST_PORT)) begin
                        rec_d.port    = MAX_PORT_W'(cap_idx);
                        rec_d.latency = sink_latency_i[cap_idx];
                        rec_d.count   = sink_count_i[cap_idx];
                        rec_d.error   = sink_error_i[cap_idx];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            meas_len_q  <= 16'd0;
            drain_len_q <= 16'd0;
            ts_q        <= 16'd0;
            port_q      <= '0;
            rec_q       <= '0;
            rec_valid_q <= 1'b0;
            src_en_q    <= 1'b0;
            sink_clr_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            meas_len_q  <= meas_len_d;
            drain_len_q <= drain_len_d;
            ts_q        <= ts_q + 16'd1;
            port_q      <= port_d;
            rec_q       <= rec_d;
            rec_valid_q <= rec_valid_d;
            src_en_q    <= (state_d == ST_WARMUP) || (state_d == ST_MEASURE);
            sink_clr_q  <= (state_d == ST_IDLE) || (state_d == ST_WARMUP);
            busy_q      <= (state_d == ST_WARMUP) || (state_d == ST_MEASURE) ||
                           (state_d == ST_DRAIN) || (state_d == ST_READOUT);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign timestamp_o   = ts_q;
    assign src_en_o      = src_en_q;
    assign sink_clr_o    = sink_clr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign state_o       = state_q;
    assign rec_valid_o   = rec_valid_q;
    assign rec_port_o    = rec_q.port[PORT_W-1:0];
    assign rec_latency_o = rec_q.latency;
    assign rec_count_o   = rec_q.count;
    assign rec_error_o   = rec_q.error;

    logic unused_port_bits;
    assign unused_port_bits = ^rec_q.port;

`ifdef SINK_SCHED_TOTALS_EN
    logic [31:0] total_latency_q;
    logic [23:0] total_count_q;
    logic        any_error_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_totals) begin
            total_latency_q <= 32'd0;
            total_count_q   <= 24'd0;
            any_error_q     <= 1'b0;
        end else if (accept) begin
            total_latency_q <= total_latency_q + {8'd0, rec_q.latency};
            total_count_q   <= total_count_q + {8'd0, rec_q.count};
            any_error_q     <= any_error_q | rec_q.error;
        end
    end

    assign total_latency_o = total_latency_q;
    assign total_count_o   = total_count_q;
    assign any_error_o     = any_error_q;
`else
    logic unused_totals;
    assign unused_totals = clr_totals ^ accept;
`endif

endmodule
